// File: rtl/hazard_forward_unit_pkg.sv
// Shared types and constants for the hazard/forwarding controller.
// The scoreboard entry carries a fixed-width rd so one struct serves every REG_ADDR_W up to RD_MAX_W.
package hazard_forward_unit_pkg;

  localparam int RD_MAX_W = 8;
  localparam int FWD_RF   = 0;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  typedef struct packed {
    logic                valid;
    logic [RD_MAX_W-1:0] rd;
    logic                is_load;
  } entry_t;

  // Load data only exists from stage load_lat onward; ALU results are usable at any stage.
  function automatic logic stage_ready(input logic is_load, input int stage, input int load_lat);
    return !is_load || (stage >= load_lat);
  endfunction

endpackage

// File: rtl/hazard_forward_unit_match.sv
// Priority match of one decode source register against the in-flight writer scoreboard.
// Reports whether a writer exists, which stage holds the youngest one, and if its value is usable yet.
module hazard_match
  import hazard_forward_unit_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int LOAD_LAT = 2,
  parameter int SEL_W    = 2
) (
  input  logic                use_rs,
  input  logic [RD_MAX_W-1:0] rs,
  input  entry_t              sb [DEPTH],
  output logic                hit,
  output logic [SEL_W-1:0]    sel,
  output logic                ready
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    hit   = 1'b0;
    sel   = '0;
    ready = 1'b0;
    // Scan oldest to youngest so the youngest matching writer is the last to overwrite.
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (use_rs && sb[k].valid && (sb[k].rd == rs)) begin
        hit   = 1'b1;
        sel   = SEL_W'(k + 1);
        ready = stage_ready(sb[k].is_load, k + 1, LOAD_LAT);
      end
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Pipeline hazard and forwarding controller: writer scoreboard, forwarding selects,
// load-use stalls, branch squash, write-back port and the STOP drain/halt sequence.
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int  REG_ADDR_W = 2,
  parameter int  DEPTH      = 2,
  parameter int  LOAD_LAT   = 2,
  parameter int  CNT_W      = 16,
  localparam int SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  id_wr_en,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_is_load,
  input  logic                  id_stop,
  input  logic                  br_flush,
  output logic                  stall,
  output logic [SEL_W-1:0]      fwd_sel_r1,
  output logic [SEL_W-1:0]      fwd_sel_r2,
  output logic                  rf_write,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic                  halted,
  output logic [CNT_W-1:0]      stall_count
);

  entry_t     sb [DEPTH];
  logic [1:0] state;

  logic             hit1, ready1, hit2, ready2;
  logic [SEL_W-1:0] sel1, sel2;
  logic             run, hazard, issue, sb_empty;

  hazard_match #(.DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .SEL_W(SEL_W)) u_match_rs1 (
    .use_rs (id_use_rs1),
    .rs     (RD_MAX_W'(id_rs1)),
    .sb     (sb),
    .hit    (hit1),
    .sel    (sel1),
    .ready  (ready1)
  );

  hazard_match #(.DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .SEL_W(SEL_W)) u_match_rs2 (
    .use_rs (id_use_rs2),
    .rs     (RD_MAX_W'(id_rs2)),
    .sb     (sb),
    .hit    (hit2),
    .sel    (sel2),
    .ready  (ready2)
  );

  assign run    = (state == ST_RUN);
  assign hazard = (hit1 & ~ready1) | (hit2 & ~ready2);
  assign stall  = id_valid & run & ~br_flush & hazard;
  assign issue  = id_valid & ~stall & ~br_flush & run;

  assign fwd_sel_r1 = (hit1 & ready1) ? sel1 : SEL_W'(FWD_RF);
  assign fwd_sel_r2 = (hit2 & ready2) ? sel2 : SEL_W'(FWD_RF);

  assign rf_write = sb[DEPTH-1].valid;
  assign rf_waddr = sb[DEPTH-1].rd[REG_ADDR_W-1:0];
  assign halted   = (state == ST_HALTED);

  always_comb begin
    sb_empty = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      if (sb[k].valid) sb_empty = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: the scoreboard is a handful of flops, not a RAM, so it is reset; stale valid bits would fake hazards.
      for (int k = 0; k < DEPTH; k++) sb[k] <= '0;
      state       <= ST_RUN;
      stall_count <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage read its neighbour's pre-edge value, giving a true shift.
      sb[0] <= '{valid: issue & id_wr_en & ~id_stop, rd: RD_MAX_W'(id_rd), is_load: id_is_load};
      for (int k = 1; k < DEPTH; k++) sb[k] <= sb[k-1];

      if (stall && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);

      case (state)
        ST_RUN:   if (issue && id_stop) state <= ST_DRAIN;
        ST_DRAIN: if (sb_empty) state <= ST_HALTED;
        default:  state <= state;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench: directed vector table, hand-written STOP/reset/saturation sequences,
// then randomized traffic compared against a stage-list reference model.
module tb_hazard_forward_unit;

  localparam int D    = 2;
  localparam int LL   = 2;
  localparam int CMAX = 65535;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       id_valid, id_use_rs1, id_use_rs2, id_wr_en, id_is_load, id_stop, br_flush;
  logic [1:0] id_rs1, id_rs2, id_rd;
  logic       stall, rf_write, halted;
  logic [1:0] fwd_sel_r1, fwd_sel_r2, rf_waddr;
  logic [15:0] stall_count;

  logic       s_valid, s_use_rs1, s_use_rs2, s_wr_en, s_is_load, s_stop, s_flush;
  logic [1:0] s_rs1, s_rs2, s_rd;
  logic       s_stall, s_rf_write, s_halted;
  logic [1:0] s_fwd1, s_fwd2, s_waddr, s_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  hazard_forward_unit #(.REG_ADDR_W(2), .DEPTH(D), .LOAD_LAT(LL), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_wr_en(id_wr_en), .id_rd(id_rd),
    .id_is_load(id_is_load), .id_stop(id_stop), .br_flush(br_flush), .stall(stall),
    .fwd_sel_r1(fwd_sel_r1), .fwd_sel_r2(fwd_sel_r2), .rf_write(rf_write), .rf_waddr(rf_waddr),
    .halted(halted), .stall_count(stall_count)
  );

  hazard_forward_unit #(.REG_ADDR_W(2), .DEPTH(3), .LOAD_LAT(3), .CNT_W(2)) dut_sat (
    .clock(clock), .reset(reset), .id_valid(s_valid), .id_rs1(s_rs1), .id_rs2(s_rs2),
    .id_use_rs1(s_use_rs1), .id_use_rs2(s_use_rs2), .id_wr_en(s_wr_en), .id_rd(s_rd),
    .id_is_load(s_is_load), .id_stop(s_stop), .br_flush(s_flush), .stall(s_stall),
    .fwd_sel_r1(s_fwd1), .fwd_sel_r2(s_fwd2), .rf_write(s_rf_write), .rf_waddr(s_waddr),
    .halted(s_halted), .stall_count(s_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] rs1, input logic [1:0] rs2,
                       input logic u1, input logic u2, input logic wr, input logic [1:0] rd,
                       input logic ld, input logic stp, input logic fl);
    id_valid = v;  id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_wr_en = wr; id_rd = rd;   id_is_load = ld; id_stop = stp; br_flush = fl;
  endtask

  task automatic drive_sat(input logic v, input logic [1:0] rs1, input logic u1,
                           input logic wr, input logic [1:0] rd, input logic ld);
    s_valid = v; s_rs1 = rs1; s_rs2 = 2'd0; s_use_rs1 = u1; s_use_rs2 = 1'b0;
    s_wr_en = wr; s_rd = rd; s_is_load = ld; s_stop = 1'b0; s_flush = 1'b0;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic advance();
    @(posedge clock);
    #1;
  endtask

  // ---------------- reference model: list of writers indexed by pipeline age ----------------
  bit         m_v  [1:D];
  logic [1:0] m_rd [1:D];
  bit         m_ld [1:D];
  int         m_mode;   // 0 running, 1 draining, 2 halted
  int         m_cnt;

  bit         e_stall, e_rfw, e_halt, e_pend1, e_pend2;
  int         e_f1, e_f2;
  logic [1:0] e_wa;

  task automatic model_reset();
    for (int k = 1; k <= D; k++) begin m_v[k] = 0; m_rd[k] = 0; m_ld[k] = 0; end
    m_mode = 0;
    m_cnt  = 0;
  endtask

  task automatic lookup(input bit used, input logic [1:0] rs, output bit pend, output int sel);
    pend = 0;
    sel  = 0;
    if (used) begin
      for (int age = 1; age <= D; age++) begin
        if (m_v[age] && m_rd[age] == rs) begin
          if (!m_ld[age] || age >= LL) sel = age;
          else pend = 1;
          break;
        end
      end
    end
  endtask

  task automatic model_eval();
    lookup(id_use_rs1, id_rs1, e_pend1, e_f1);
    lookup(id_use_rs2, id_rs2, e_pend2, e_f2);
    e_stall = id_valid && m_mode == 0 && !br_flush && (e_pend1 || e_pend2);
    e_rfw   = m_v[D];
    e_wa    = m_rd[D];
    e_halt  = (m_mode == 2);
  endtask

  task automatic model_advance();
    bit issue, empty;
    issue = id_valid && !e_stall && !br_flush && m_mode == 0;
    empty = 1;
    for (int k = 1; k <= D; k++) if (m_v[k]) empty = 0;
    for (int k = D; k >= 2; k--) begin
      m_v[k] = m_v[k-1]; m_rd[k] = m_rd[k-1]; m_ld[k] = m_ld[k-1];
    end
    m_v[1]  = issue && id_wr_en && !id_stop;
    m_rd[1] = id_rd;
    m_ld[1] = id_is_load;
    if (m_mode == 0 && issue && id_stop) m_mode = 1;
    else if (m_mode == 1 && empty) m_mode = 2;
    if (e_stall && m_cnt < CMAX) m_cnt++;
  endtask

  task automatic do_reset(input bit check_state);
    idle();
    drive_sat(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    #1;
    if (check_state) begin
      check("rst_stall", 32'(stall), 0);
      check("rst_fwd1", 32'(fwd_sel_r1), 0);
      check("rst_fwd2", 32'(fwd_sel_r2), 0);
      check("rst_rf_write", 32'(rf_write), 0);
      check("rst_rf_waddr", 32'(rf_waddr), 0);
      check("rst_halted", 32'(halted), 0);
      check("rst_count", 32'(stall_count), 0);
      check("rst_sat_count", 32'(s_cnt), 0);
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       v, u1, u2, wr, ld, stp, fl;
    logic [1:0] rs1, rs2, rd;
    logic       x_stall, chk_fwd, x_rfw, x_halt;
    logic [1:0] x_f1, x_f2, x_wa;
    int         x_cnt;
  } vec_t;

  vec_t vecs [13];

  function automatic vec_t mk(input logic v, input logic [1:0] rs1, input logic [1:0] rs2,
                              input logic u1, input logic u2, input logic wr, input logic [1:0] rd,
                              input logic ld, input logic stp, input logic fl,
                              input logic xs, input logic cf, input logic [1:0] f1, input logic [1:0] f2,
                              input logic rfw, input logic [1:0] wa, input logic xh, input int cnt);
    vec_t r;
    r.v = v; r.rs1 = rs1; r.rs2 = rs2; r.u1 = u1; r.u2 = u2; r.wr = wr; r.rd = rd;
    r.ld = ld; r.stp = stp; r.fl = fl;
    r.x_stall = xs; r.chk_fwd = cf; r.x_f1 = f1; r.x_f2 = f2;
    r.x_rfw = rfw; r.x_wa = wa; r.x_halt = xh; r.x_cnt = cnt;
    return r;
  endfunction

  initial begin
    //            v rs1 rs2 u1 u2 wr rd ld st fl | stall chk f1 f2 rfw wa halt cnt
    vecs[0]  = mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 0); // ADD r1
    vecs[1]  = mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0, 0, 0, 0, 0); // read r1 from stage 1
    vecs[2]  = mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 0,   0, 1, 2, 0, 1, 1, 0, 0); // read r1 from stage 2, write-back r1
    vecs[3]  = mk(1, 0, 0, 0, 0, 1, 2, 1, 0, 0,   0, 1, 0, 0, 0, 0, 0, 0); // LOAD r2
    vecs[4]  = mk(1, 0, 2, 0, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0); // load-use stall
    vecs[5]  = mk(1, 0, 2, 0, 1, 0, 0, 0, 0, 0,   0, 1, 0, 2, 1, 2, 0, 1); // released, load forwarded
    vecs[6]  = mk(1, 0, 0, 0, 0, 1, 3, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 1); // ADD r3
    vecs[7]  = mk(1, 3, 0, 0, 0, 1, 3, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 1); // SUB r3, rs1 not used
    vecs[8]  = mk(1, 3, 3, 1, 1, 0, 0, 0, 0, 0,   0, 1, 1, 1, 1, 3, 0, 1); // youngest r3 wins
    vecs[9]  = mk(1, 0, 0, 0, 0, 1, 0, 1, 0, 0,   0, 1, 0, 0, 1, 3, 0, 1); // LOAD r0
    vecs[10] = mk(1, 0, 0, 1, 0, 1, 1, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0, 1); // dependent writer flushed
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 1, 0, 0, 1); // LOAD r0 writes back
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0, 1); // flushed slot is a bubble
  end

  initial begin
    int hc;
    idle();
    drive_sat(0, 0, 0, 0, 0, 0);
    #2;
    do_reset(1);

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].v, vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2, vecs[i].wr,
            vecs[i].rd, vecs[i].ld, vecs[i].stp, vecs[i].fl);
      @(negedge clock);
      check($sformatf("vec%0d_stall", i), 32'(stall), 32'(vecs[i].x_stall));
      if (vecs[i].chk_fwd) begin
        check($sformatf("vec%0d_fwd1", i), 32'(fwd_sel_r1), 32'(vecs[i].x_f1));
        check($sformatf("vec%0d_fwd2", i), 32'(fwd_sel_r2), 32'(vecs[i].x_f2));
      end
      check($sformatf("vec%0d_rf_write", i), 32'(rf_write), 32'(vecs[i].x_rfw));
      if (vecs[i].x_rfw) check($sformatf("vec%0d_rf_waddr", i), 32'(rf_waddr), 32'(vecs[i].x_wa));
      check($sformatf("vec%0d_halted", i), 32'(halted), 32'(vecs[i].x_halt));
      check($sformatf("vec%0d_count", i), 32'(stall_count), 32'(vecs[i].x_cnt));
      advance();
    end

    // STOP drain: LOAD r0, ADD r1, STOP, then halt is held and new work is ignored.
    do_reset(0);
    drive(1, 0, 0, 0, 0, 1, 0, 1, 0, 0); advance();
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 0); advance();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clock); check("stop_accept_halted", 32'(halted), 0); check("stop_accept_stall", 32'(stall), 0);
    advance(); idle();
    @(negedge clock); check("drain1_halted", 32'(halted), 0); check("drain1_rf_write", 32'(rf_write), 1);
    check("drain1_rf_waddr", 32'(rf_waddr), 1);
    advance();
    @(negedge clock); check("drain2_halted", 32'(halted), 0); check("drain2_rf_write", 32'(rf_write), 0);
    advance();
    @(negedge clock); check("halt_reached", 32'(halted), 1);
    advance(); drive(1, 0, 0, 0, 0, 1, 2, 0, 0, 0);
    @(negedge clock); check("halt_hold", 32'(halted), 1); check("halt_no_stall", 32'(stall), 0);
    advance(); idle(); advance();
    @(negedge clock); check("halt_no_issue", 32'(rf_write), 0); check("halt_hold2", 32'(halted), 1);
    advance();

    // STOP behind a load-use hazard: stall first, then accept.
    do_reset(0);
    drive(1, 0, 0, 0, 0, 1, 1, 1, 0, 0); advance();
    drive(1, 1, 0, 1, 0, 0, 0, 0, 1, 0);
    @(negedge clock); check("stop_lu_stall", 32'(stall), 1); advance();
    @(negedge clock); check("stop_lu_release", 32'(stall), 0); advance(); idle();
    @(negedge clock); check("stop_lu_drain", 32'(halted), 0); advance();
    @(negedge clock); check("stop_lu_halted", 32'(halted), 1); advance();

    // STOP with branch flush: STOP ignored, pipeline keeps running.
    do_reset(0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    @(negedge clock); check("stop_flush_stall", 32'(stall), 0); advance(); idle(); advance();
    @(negedge clock); check("stop_flush_not_halted", 32'(halted), 0); advance();
    drive(1, 0, 0, 0, 0, 1, 3, 0, 0, 0); advance();
    drive(1, 3, 0, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clock); check("stop_flush_still_runs", 32'(fwd_sel_r1), 1); advance();

    // Asynchronous reset in the middle of a drain.
    do_reset(0);
    drive(1, 0, 0, 0, 0, 1, 0, 1, 0, 0); advance();
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 0); advance();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0); advance(); idle();
    @(negedge clock); check("mid_drain_rf_write", 32'(rf_write), 1);
    reset = 1'b0;
    #1;
    check("async_rst_halted", 32'(halted), 0);
    check("async_rst_rf_write", 32'(rf_write), 0);
    @(posedge clock); #1; reset = 1'b1;
    drive(1, 0, 0, 0, 0, 1, 2, 0, 0, 0); advance();
    drive(1, 2, 0, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clock); check("post_rst_run_fwd", 32'(fwd_sel_r1), 1); check("post_rst_halted", 32'(halted), 0);
    advance();

    // Saturating counter on the DEPTH=3, LOAD_LAT=3, CNT_W=2 instance.
    do_reset(0);
    for (int rep = 0; rep < 2; rep++) begin
      drive_sat(1, 0, 0, 1, 0, 1); advance();
      drive_sat(1, 0, 1, 0, 0, 0);
      for (int s = 0; s < 2; s++) begin
        @(negedge clock); check($sformatf("sat%0d_stall%0d", rep, s), 32'(s_stall), 1); advance();
      end
      @(negedge clock);
      check($sformatf("sat%0d_release", rep), 32'(s_stall), 0);
      check($sformatf("sat%0d_fwd", rep), 32'(s_fwd1), 3);
      check($sformatf("sat%0d_count", rep), 32'(s_cnt), rep == 0 ? 2 : 3);
      advance();
    end
    drive_sat(0, 0, 0, 0, 0, 0);
    @(negedge clock); check("sat_hold", 32'(s_cnt), 3); advance();

    // Randomized traffic against the reference model.
    do_reset(0);
    hc = 0;
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(3) != 0, 2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 2'($urandom), $urandom_range(2) == 0, $urandom_range(39) == 0,
            $urandom_range(7) == 0);
      @(negedge clock);
      model_eval();
      check("rnd_stall", 32'(stall), 32'(e_stall));
      if (!e_stall && !e_pend1) check("rnd_fwd1", 32'(fwd_sel_r1), 32'(e_f1));
      if (!e_stall && !e_pend2) check("rnd_fwd2", 32'(fwd_sel_r2), 32'(e_f2));
      check("rnd_rf_write", 32'(rf_write), 32'(e_rfw));
      if (e_rfw) check("rnd_rf_waddr", 32'(rf_waddr), 32'(e_wa));
      check("rnd_halted", 32'(halted), 32'(e_halt));
      check("rnd_count", stall_count, 32'(m_cnt));
      model_advance();
      advance();
      if (m_mode == 2) hc++;
      if (hc > 3) begin
        do_reset(0);
        hc = 0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
